// File: rtl/adc16dv160_pkg.sv
// rtl/adc16dv160_pkg.sv - shared types and constants for the ADC16DV160 sample packer
//
// Purpose : FSM state encoding, trigger mode encoding, default widths and a
//           small helper that says whether a trigger mode is free-running.
// Contents: state_e, trig_mode_e, SAMPLE_W_DEF, DECIM_W_DEF, is_free_run()
package adc16dv160_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int DECIM_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    WAIT_TRIG = 2'd2,
    RUN       = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TRIG_FREE = 2'd0,
    TRIG_RISE = 2'd1,
    TRIG_FALL = 2'd2,
    TRIG_RSVD = 2'd3
  } trig_mode_e;

  // The reserved encoding behaves exactly like free-run.
  function automatic logic is_free_run(input trig_mode_e m);
    return (m == TRIG_FREE) || (m == TRIG_RSVD);
  endfunction

endpackage

// File: rtl/adc16dv160_trigger_detect.sv
// rtl/adc16dv160_trigger_detect.sv - combinational level-crossing detector
//
// Purpose : Flags a rising or falling crossing of a threshold between two
//           consecutive samples. Compare is two's complement when SIGNED=1,
//           unsigned otherwise. Free-run/reserved modes never fire.
// Ports   : s_prev_i  older sample
//           s_cur_i   newer sample (the trigger sample when fire_o=1)
//           lvl_i     threshold
//           mode_i    trigger mode
//           fire_o    crossing detected
module adc16dv160_trigger_detect
  import adc16dv160_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter bit SIGNED   = 1'b1
) (
  input  logic [SAMPLE_W-1:0] s_prev_i,
  input  logic [SAMPLE_W-1:0] s_cur_i,
  input  logic [SAMPLE_W-1:0] lvl_i,
  input  trig_mode_e          mode_i,
  output logic                fire_o
);

  // Extending by one bit (sign bit or zero) lets a single signed compare
  // serve both the signed and unsigned interpretations.
  logic signed [SAMPLE_W:0] prev_x;
  logic signed [SAMPLE_W:0] cur_x;
  logic signed [SAMPLE_W:0] lvl_x;

  assign prev_x = $signed({SIGNED & s_prev_i[SAMPLE_W-1], s_prev_i});
  assign cur_x  = $signed({SIGNED & s_cur_i[SAMPLE_W-1],  s_cur_i});
  assign lvl_x  = $signed({SIGNED & lvl_i[SAMPLE_W-1],    lvl_i});

  always_comb begin
    fire_o = 1'b0;
    case (mode_i)
      TRIG_RISE: fire_o = (prev_x < lvl_x) && (cur_x >= lvl_x);
      TRIG_FALL: fire_o = (prev_x > lvl_x) && (cur_x <= lvl_x);
      default:   fire_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/adc16dv160_sample_packer.sv
// rtl/adc16dv160_sample_packer.sv - ADC sample decimator, trigger and 2:1 word packer
//
// Purpose : adc_clk-domain front end ahead of the dual-clock FIFO. Registers
//           raw samples, optionally decimates and waits for a level trigger,
//           and packs two kept samples per word (older in the low half).
// Ports   : adc_clk     sample clock
//           adc_rst     asynchronous active-high reset
//           adc_data    raw sample, one per clock
//           enable      run request
//           decim       keep 1 of every decim+1 samples (latched in IDLE)
//           trig_mode   0/3 free-run, 1 rising, 2 falling (latched in IDLE)
//           trig_level  trigger threshold (latched in IDLE)
//           pattern     replace kept samples by a ramp (latched in IDLE)
//           out_full    downstream FIFO full
//           out_data    packed word
//           out_valid   one-cycle write strobe
//           triggered   high while in RUN
//           overflow    sticky: a word was dropped on out_full
module adc16dv160_sample_packer
  import adc16dv160_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int DECIM_W  = DECIM_W_DEF,
  parameter int SIGNED   = 1
) (
  input  logic                  adc_clk,
  input  logic                  adc_rst,
  input  logic [SAMPLE_W-1:0]   adc_data,
  input  logic                  enable,
  input  logic [DECIM_W-1:0]    decim,
  input  logic [1:0]            trig_mode,
  input  logic [SAMPLE_W-1:0]   trig_level,
  input  logic                  pattern,
  input  logic                  out_full,
  output logic [2*SAMPLE_W-1:0] out_data,
  output logic                  out_valid,
  output logic                  triggered,
  output logic                  overflow
);

  state_e                  state_q, state_d;
  logic [SAMPLE_W-1:0]     s_cur_q, s_prev_q;
  logic [DECIM_W-1:0]      decim_q, cnt_q, cnt_d;
  trig_mode_e              mode_q;
  logic [SAMPLE_W-1:0]     lvl_q;
  logic                    pattern_q;
  logic                    half_q;
  logic [SAMPLE_W-1:0]     lo_q;
  logic [SAMPLE_W-1:0]     ramp_q;
  logic                    live_q;
  logic [2*SAMPLE_W-1:0]   out_data_q;
  logic                    out_valid_q, triggered_q, overflow_q;

  logic                    fire;
  logic                    run_now, trig_now, consume, keep;
  logic [SAMPLE_W-1:0]     sample_d;

  adc16dv160_trigger_detect #(
    .SAMPLE_W (SAMPLE_W),
    .SIGNED   (SIGNED != 0)
  ) u_trig (
    .s_prev_i (s_prev_q),
    .s_cur_i  (s_cur_q),
    .lvl_i    (lvl_q),
    .mode_i   (mode_q),
    .fire_o   (fire)
  );

  // live_q tags the sample now in s_cur_q as captured while RUN was active
  // (or as the one right after the trigger sample). This keeps the sample
  // that was on adc_data during the first RUN cycle as the first kept one,
  // rather than a sample captured back in ARM.
  assign run_now  = enable && (state_q == RUN) && live_q;
  // The trigger sample itself is consumed on the edge the trigger fires.
  assign trig_now = enable && (state_q == WAIT_TRIG) && fire;
  assign consume  = run_now || trig_now;
  assign keep     = consume && (cnt_q == '0);
  assign sample_d = pattern_q ? ramp_q : s_cur_q;
  assign cnt_d    = (cnt_q == decim_q) ? '0 : cnt_q + DECIM_W'(1);

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      state_d = ARM;
        ARM:       state_d = (is_free_run(mode_q) || pattern_q) ? RUN : WAIT_TRIG;
        WAIT_TRIG: state_d = fire ? RUN : WAIT_TRIG;
        default:   state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      state_q     <= IDLE;
      s_cur_q     <= '0;
      s_prev_q    <= '0;
      decim_q     <= '0;
      cnt_q       <= '0;
      mode_q      <= TRIG_FREE;
      lvl_q       <= '0;
      pattern_q   <= 1'b0;
      half_q      <= 1'b0;
      lo_q        <= '0;
      ramp_q      <= '0;
      live_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      s_cur_q     <= adc_data;
      s_prev_q    <= s_cur_q;
      state_q     <= state_d;
      triggered_q <= (state_d == RUN);
      live_q      <= trig_now || (enable && (state_q == RUN));
      out_valid_q <= 1'b0;

      if ((state_q == IDLE) && enable) begin
        decim_q    <= decim;
        mode_q     <= trig_mode_e'(trig_mode);
        lvl_q      <= trig_level;
        pattern_q  <= pattern;
        cnt_q      <= '0;
        half_q     <= 1'b0;
        ramp_q     <= '0;
        overflow_q <= 1'b0;
      end

      if (consume) begin
        cnt_q <= cnt_d;
        if (keep) begin
          ramp_q <= ramp_q + SAMPLE_W'(1);
          if (half_q) begin
            half_q <= 1'b0;
            // A full FIFO drops this word only; the next kept sample still
            // starts a fresh pair, so alignment is never shifted.
            if (out_full) begin
              overflow_q <= 1'b1;
            end else begin
              out_valid_q <= 1'b1;
              out_data_q  <= {sample_d, lo_q};
            end
          end else begin
            lo_q   <= sample_d;
            half_q <= 1'b1;
          end
        end
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign triggered = triggered_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_adc16dv160_sample_packer.sv
// tb/tb_adc16dv160_sample_packer.sv - self-checking bench for adc16dv160_sample_packer
module tb_adc16dv160_sample_packer;

  typedef struct {
    logic [7:0]  decim;
    logic [1:0]  mode;
    logic        pattern;
    logic [15:0] lvl;
    logic [15:0] base;
    logic [15:0] step;
    int          ncyc;
    int          drop_idx;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] adc_data;
  logic        enable;
  logic [7:0]  decim;
  logic [1:0]  trig_mode;
  logic [15:0] trig_level;
  logic        pattern;
  logic        out_full;
  logic [31:0] out_data_s, out_data_u;
  logic        out_valid_s, out_valid_u;
  logic        triggered_s, triggered_u;
  logic        overflow_s, overflow_u;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   rel_m;
  bit   mon_on = 1'b0;
  int   trig_s_at, trig_u_at;
  exp_t exp_q[$];
  exp_t got_e;
  vec_t tbl[9];

  adc16dv160_sample_packer #(.SAMPLE_W(16), .DECIM_W(8), .SIGNED(1)) dut_s (
    .adc_clk(clk), .adc_rst(rst), .adc_data(adc_data), .enable(enable),
    .decim(decim), .trig_mode(trig_mode), .trig_level(trig_level),
    .pattern(pattern), .out_full(out_full), .out_data(out_data_s),
    .out_valid(out_valid_s), .triggered(triggered_s), .overflow(overflow_s)
  );

  adc16dv160_sample_packer #(.SAMPLE_W(16), .DECIM_W(8), .SIGNED(0)) dut_u (
    .adc_clk(clk), .adc_rst(rst), .adc_data(adc_data), .enable(enable),
    .decim(decim), .trig_mode(trig_mode), .trig_level(trig_level),
    .pattern(pattern), .out_full(out_full), .out_data(out_data_u),
    .out_valid(out_valid_u), .triggered(triggered_u), .overflow(overflow_u)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc - start_cyc);
    end
  endtask

  function automatic vec_t mk(input int d, input int m, input bit p, input int lvl,
                              input int base, input int step, input int ncyc, input int drop);
    vec_t v;
    v.decim = 8'(d); v.mode = 2'(m); v.pattern = p; v.lvl = 16'(lvl);
    v.base = 16'(base); v.step = 16'(step); v.ncyc = ncyc; v.drop_idx = drop;
    return v;
  endfunction

  // Sample driven in cycle t of a run; cycle 2 carries v.base.
  function automatic logic [15:0] dat(input vec_t v, input int t);
    logic [31:0] x;
    x = 32'(v.base) + 32'(v.step) * 32'(t - 2);
    return x[15:0];
  endfunction

  function automatic bit fires(input logic [15:0] p, input logic [15:0] c,
                               input logic [15:0] l, input logic [1:0] m, input bit sg);
    int ip, ic, il;
    if (sg) begin
      ip = int'($signed(p)); ic = int'($signed(c)); il = int'($signed(l));
    end else begin
      ip = int'({16'd0, p}); ic = int'({16'd0, c}); il = int'({16'd0, l});
    end
    if (m == 2'd1) return (ip < il) && (ic >= il);
    if (m == 2'd2) return (ip > il) && (ic <= il);
    return 1'b0;
  endfunction

  function automatic bit is_free(input vec_t v);
    return v.pattern || (v.mode == 2'd0) || (v.mode == 2'd3);
  endfunction

  // Cycle in which the first kept sample is driven, -1 if never.
  function automatic int first_kept(input vec_t v, input bit sg);
    if (is_free(v)) return 2;
    for (int t = 1; t <= v.ncyc - 2; t++)
      if (fires(dat(v, t - 1), dat(v, t), v.lvl, v.mode, sg)) return t;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      rel_m = cyc - start_cyc;
      if (out_valid_s) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL stray_word: out_data 0x%0h at cycle %0d, none expected", out_data_s, rel_m);
        end else begin
          got_e = exp_q.pop_front();
          check("word_data", out_data_s, got_e.word);
          check("word_cycle", rel_m, got_e.cyc);
        end
      end
      if (triggered_s && trig_s_at < 0) trig_s_at = rel_m;
      if (triggered_u && trig_u_at < 0) trig_u_at = rel_m;
      if (rel_m == 1) check("ovf_clear_on_arm", overflow_s, 0);
    end
  end

  task automatic run_vec(input vec_t v);
    int f, fu, per, j, exp_ts, exp_tu;
    bit full_next, exp_ovf;
    exp_t e;
    logic [15:0] lo, hi;
    decim = v.decim; trig_mode = v.mode; pattern = v.pattern; trig_level = v.lvl;
    f  = first_kept(v, 1'b1);
    fu = first_kept(v, 1'b0);
    exp_ts = (f < 0)  ? -1 : (is_free(v) ? 2 : f + 2);
    exp_tu = (fu < 0) ? -1 : (is_free(v) ? 2 : fu + 2);
    per = int'(v.decim) + 1;
    exp_ovf = 1'b0; full_next = 1'b0;
    trig_s_at = -1; trig_u_at = -1;
    exp_q.delete();
    start_cyc = cyc;
    mon_on = 1'b1;
    for (int t = 0; t < v.ncyc; t++) begin
      enable = 1'b1;
      adc_data = dat(v, t);
      out_full = full_next;
      full_next = 1'b0;
      if (f >= 0 && t >= f && ((t - f) % per) == 0) begin
        j = (t - f) / per;
        if ((j % 2) == 1 && t <= v.ncyc - 2) begin
          hi = v.pattern ? 16'(j)     : dat(v, t);
          lo = v.pattern ? 16'(j - 1) : dat(v, t - per);
          if ((j / 2) == v.drop_idx) begin
            full_next = 1'b1;
            exp_ovf = 1'b1;
          end else begin
            e.word = {hi, lo};
            e.cyc = t + 2;
            exp_q.push_back(e);
          end
        end
      end
      @(posedge clk); #1;
    end
    enable = 1'b0;
    out_full = 1'b0;
    for (int t = v.ncyc; t < v.ncyc + 6; t++) begin
      adc_data = dat(v, t);
      @(posedge clk); #1;
    end
    mon_on = 1'b0;
    check("trig_rise_signed", trig_s_at, exp_ts);
    check("trig_rise_unsigned", trig_u_at, exp_tu);
    check("words_outstanding", exp_q.size(), 0);
    check("overflow_end", overflow_s, exp_ovf);
    check("triggered_idle", triggered_s, 0);
  endtask

  initial begin
    // free-run decim 0, first pair 0x0001/0x0002
    tbl[0] = mk(0, 0, 1'b0, 16'h0000, 16'h0001, 16'h0001, 12, -1);
    // pattern overrides trigger mode, decim 2
    tbl[1] = mk(2, 1, 1'b1, 16'h0000, 16'h1234, 16'h0007, 20, -1);
    // rising through 0x0100
    tbl[2] = mk(0, 1, 1'b0, 16'h0100, 16'h00F0, 16'h0010, 12, -1);
    // falling at 0x8000: only the two's complement view sees a crossing
    tbl[3] = mk(0, 2, 1'b0, 16'h8000, 16'h7FFF, 16'h0001, 10, -1);
    // second word dropped by out_full
    tbl[4] = mk(0, 0, 1'b0, 16'h0000, 16'h0A00, 16'h0003, 14, 1);
    // reserved mode = free-run, decim 3, partial pair at enable drop
    tbl[5] = mk(3, 3, 1'b0, 16'h0000, 16'h4000, 16'h0111, 30, -1);
    // rising through 0 signed, decim 1
    tbl[6] = mk(1, 1, 1'b0, 16'h0000, 16'hFFF0, 16'h0004, 20, -1);
    // falling through 0x0100, same result in both views
    tbl[7] = mk(0, 2, 1'b0, 16'h0100, 16'h0130, 16'hFFF0, 12, -1);
    // enable dropped right after the first kept sample
    tbl[8] = mk(0, 0, 1'b0, 16'h0000, 16'h5555, 16'h0001, 4, -1);

    rst = 1'b1; enable = 1'b0; adc_data = 16'h0; decim = 8'h0; trig_mode = 2'd0;
    trig_level = 16'h0; pattern = 1'b0; out_full = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_data", out_data_s, 0);
    check("rst_out_valid", out_valid_s, 0);
    check("rst_triggered", triggered_s, 0);
    check("rst_overflow", overflow_s, 0);
    check("rst_u_out_data", out_data_u, 0);
    check("rst_u_out_valid", out_valid_u, 0);
    check("rst_u_triggered", triggered_u, 0);
    check("rst_u_overflow", overflow_u, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Async reset while a word strobe is on the output.
    decim = 8'd0; trig_mode = 2'd0; pattern = 1'b0; trig_level = 16'h0;
    start_cyc = cyc;
    for (int t = 0; t < 5; t++) begin
      enable = 1'b1;
      adc_data = 16'(t - 1);
      @(posedge clk); #1;
    end
    check("pre_rst_out_valid", out_valid_s, 1);
    check("pre_rst_out_data", out_data_s, 32'h0002_0001);
    check("pre_rst_triggered", triggered_s, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_data", out_data_s, 0);
    check("async_rst_out_valid", out_valid_s, 0);
    check("async_rst_triggered", triggered_s, 0);
    check("async_rst_overflow", overflow_s, 0);
    @(posedge clk); @(posedge clk); #1;
    enable = 1'b0;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle_triggered", triggered_s, 0);
      check("post_rst_idle_valid", out_valid_s, 0);
    end
    @(posedge clk); #1;
    run_vec(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
